// File: rtl/mem_port_arb_pkg.sv
// Shared types and default sizes for the fetch/data memory port arbiter.
package mem_port_arb_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT  = 32'd16384;
  localparam int unsigned STARVE_MAX_DEFAULT = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Index of the current 64-bit beat within a fetch (0..2).
  typedef logic [1:0] beat_t;

  // A 10-byte fetch spans three beats only when it starts at the last byte of a word.
  function automatic beat_t last_beat(input logic [2:0] offset);
    return (offset == 3'd7) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/mem_port_arb_fetch_align.sv
// Picks the 10 instruction bytes starting at the fetch offset out of the
// three-beat little-endian fetch buffer.
module fetch_align (
  input  logic [191:0] beats,
  input  logic [2:0]   offset,
  output logic [79:0]  window
);

  // byte 'offset' of beat 0 lands in window bits 7:0
  always_comb begin
    window = beats[{offset, 3'b000} +: 80];
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates an instruction-fetch port and a data port onto one 64-bit
// memory port, with bounded starvation of fetch by data traffic.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic [79:0] f_data,
  output logic        f_ack,
  output logic        f_err,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic [63:0] m_rdata,
  output logic        m_ack,
  output logic        m_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int SW = (STARVE_MAX < 32'd1) ? 1 : $clog2(STARVE_MAX + 32'd1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [64:0]   MEM_LIM    = 65'(MEM_BYTES);

  state_t        state_r;
  beat_t         beat_r;
  logic [SW-1:0] starve_cnt_r;
  logic          is_fetch_r;
  logic          err_r;
  logic [2:0]    off_r;
  logic [63:0]   fbase_r;
  logic [191:0]  fbuf_r;

  logic [64:0]   m_end_s;
  logic [64:0]   f_end_s;
  logic          m_bad_s;
  logic          f_bad_s;
  logic          data_win_s;
  logic [63:0]   beat_addr_s;
  logic [79:0]   window_s;

  fetch_align u_align (
    .beats  (fbuf_r),
    .offset (off_r),
    .window (window_s)
  );

  // request legality, arbitration decision and next fetch beat address
  always_comb begin
    m_end_s     = {1'b0, m_addr} + 65'd7;
    f_end_s     = {1'b0, f_addr} + 65'd9;
    m_bad_s     = (m_addr[2:0] != 3'd0) || (m_end_s >= MEM_LIM);
    f_bad_s     = (f_end_s >= MEM_LIM);
    data_win_s  = m_req && (!f_req || (starve_cnt_r < STARVE_LIM));
    beat_addr_s = fbase_r + {59'd0, beat_r, 3'b000};
  end

  // arbitration FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      beat_r       <= 2'd0;
      starve_cnt_r <= '0;
      is_fetch_r   <= 1'b0;
      err_r        <= 1'b0;
      off_r        <= 3'd0;
      fbase_r      <= 64'd0;
      fbuf_r       <= 192'd0;
      f_data       <= 80'd0;
      f_ack        <= 1'b0;
      f_err        <= 1'b0;
      m_rdata      <= 64'd0;
      m_ack        <= 1'b0;
      m_err        <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 64'd0;
      mem_wdata    <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (data_win_s) begin
            is_fetch_r <= 1'b0;
            m_rdata    <= 64'd0;
            if (f_req && (starve_cnt_r < STARVE_LIM)) begin
              starve_cnt_r <= starve_cnt_r + SW'(1);
            end
            if (m_bad_s) begin
              err_r   <= 1'b1;
              state_r <= RESP;
            end else begin
              err_r     <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= m_we;
              mem_addr  <= m_addr;
              mem_wdata <= m_wdata;
              state_r   <= DATA;
            end
          end else if (f_req) begin
            is_fetch_r   <= 1'b1;
            starve_cnt_r <= '0;
            off_r        <= f_addr[2:0];
            fbase_r      <= {f_addr[63:3], 3'b000};
            beat_r       <= 2'd0;
            fbuf_r       <= 192'd0;
            if (f_bad_s) begin
              err_r   <= 1'b1;
              state_r <= RESP;
            end else begin
              err_r     <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= {f_addr[63:3], 3'b000};
              mem_wdata <= 64'd0;
              state_r   <= FETCH;
            end
          end
        end
        FETCH: begin
          // mem_ack only counts while a beat is outstanding
          if (mem_req && mem_ack) begin
            fbuf_r[{beat_r, 6'd0} +: 64] <= mem_rdata;
            mem_req <= 1'b0;
            if (beat_r == last_beat(off_r)) begin
              state_r <= RESP;
            end else begin
              beat_r <= beat_r + 2'd1;
            end
          end else if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= beat_addr_s;
          end
        end
        DATA: begin
          if (mem_ack) begin
            if (!mem_we) begin
              m_rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state_r <= RESP;
          end
        end
        RESP: begin
          // first cycle raises the ack, second cycle retires it
          if (f_ack || m_ack) begin
            f_ack   <= 1'b0;
            f_err   <= 1'b0;
            m_ack   <= 1'b0;
            m_err   <= 1'b0;
            state_r <= IDLE;
          end else if (is_fetch_r) begin
            f_ack  <= 1'b1;
            f_err  <= err_r;
            f_data <= err_r ? 80'd0 : window_s;
          end else begin
            m_ack <= 1'b1;
            m_err <= err_r;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 16384, meaning the byte size of the unified memory; addresses at or above it are illegal.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants while fetch waits.
REQ-003 Ports SHALL be exactly as follows; clocking is one clock, and reset is asynchronous and active-low:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request, held until f_ack
f_addr  in  64  fetch byte address, any alignment
f_data  out  80  10 instruction bytes from f_addr, little-endian (byte f_addr in bits 7:0)
f_ack  out  1  one-cycle fetch completion
f_err  out  1  with f_ack: f_addr+9 >= MEM_BYTES
m_req  in  1  data request, held until m_ack
m_we  in  1  1=write, 0=read
m_addr  in  64  data byte address
m_wdata  in  64  write data
m_rdata  out  64  read data, valid with m_ack
m_ack  out  1  one-cycle data completion
m_err  out  1  with m_ack: m_addr[2:0]!=0 or m_addr+7 >= MEM_BYTES
mem_req  out  1  memory access request, registered
mem_we  out  1  memory write enable
mem_addr  out  64  8-aligned memory byte address
mem_wdata  out  64  memory write data
mem_rdata  in  64  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle memory completion

Function
REQ-004 FSM states SHALL be IDLE, FETCH, DATA, RESP.
REQ-005 In IDLE with m_req and (not f_req or starve_cnt<STARVE_MAX), the block SHALL grant data; otherwise, with f_req, it SHALL grant fetch.
REQ-006 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data grant while f_req=1, and SHALL clear on every fetch grant.
REQ-007 An illegal granted request SHALL go IDLE->RESP with no mem_req, then pulse ack with err=1 and zero data.
REQ-008 A legal data grant SHALL enter DATA, drive mem_req=1, mem_we=m_we, mem_addr=m_addr and mem_wdata=m_wdata until mem_ack, and latch mem_rdata on a read.
REQ-009 A legal fetch grant SHALL enter FETCH and issue reads at (f_addr & ~7)+8*k, with k=0,1 if f_addr[2:0]<=6 and k=0,1,2 otherwise, one mem_req per beat.
REQ-010 mem_req SHALL drop in the cycle after mem_ack and re-assert no earlier than one cycle later for the next beat.
REQ-011 After the final mem_ack the block SHALL enter RESP, pulse f_ack or m_ack for exactly one cycle with data and err valid, and then return to IDLE.
REQ-012 Requests SHALL NOT be sampled in RESP or during an access; a requester re-asserting req in the cycle after ack SHALL start a new arbitration.
REQ-013 A mem_ack received in IDLE or RESP SHALL be ignored.
REQ-014 With mem_ack one cycle after mem_req, data latency SHALL be 3 cycles from req to ack for a 1-beat access, plus 2 cycles per extra fetch beat.

Reset
REQ-015 While rst_n=0, all outputs SHALL be 0, the state SHALL be IDLE, starve_cnt and the beat count SHALL be 0, and the buffers SHALL be cleared.
REQ-016 Reset asserted mid-access SHALL abandon the access immediately, and no ack SHALL be produced for it.

Structure
REQ-017 The shared package SHALL hold the state enum, the beat-count type, and the MEM_BYTES and STARVE_MAX defaults.
REQ-018 Byte extraction of the 10 bytes from the 3x64 beat buffer SHALL be a sub-module named fetch_align.

Verification
REQ-019 The bench SHALL cover, with mem_ack one cycle after each mem_req:
- Data read: m_req at m_addr=0x40 with memory returning 0x1122334455667788 -> m_ack at cycle 3, m_rdata=0x1122334455667788, m_err=0.
- Fetch: f_addr=0x103 -> reads at 0x100 and 0x108; f_data = bytes 0x103..0x10C; f_ack at cycle 5.
- Fetch: f_addr=0x107 -> reads at 0x100, 0x108 and 0x110; f_ack at cycle 7.
- Starvation: m_req and f_req held continuously -> 4 data grants, then 1 fetch grant, then starve_cnt=0.
- Errors: m_addr=0x41 -> m_err=1 with no mem_req; f_addr=MEM_BYTES-5 -> f_err=1.
- Reset: rst_n pulsed low between mem_req and mem_ack -> all outputs 0, late mem_ack ignored, no ack produced.
